// File: rtl/decryption_scheduler_pkg.sv
// rtl/decryption_scheduler_pkg.sv - shared constants, FSM states and helpers for the decryption scheduler
// Purpose: widths, engine select codes, FSM state encoding and an engine-busy lookup.
package decryption_scheduler_pkg;

  localparam int MST_DWIDTH     = 32;
  localparam int SYS_DWIDTH     = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] SEL_CAESAR  = 2'd0;
  localparam logic [1:0] SEL_SCYTALE = 2'd1;
  localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
  localparam logic [1:0] SEL_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // The invalid select reports busy so it can never start an issue.
  function automatic logic engine_busy(input logic [1:0] sel, input logic [2:0] busy);
    case (sel)
      SEL_CAESAR:  return busy[0];
      SEL_SCYTALE: return busy[1];
      SEL_ZIGZAG:  return busy[2];
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/decryption_scheduler_if.sv
// rtl/decryption_scheduler_if.sv - tagged word input stream of the decryption scheduler
// Purpose: groups the encrypted-word handshake.
// Ports: data_i (word), select_i (engine tag), valid_i, ready_o (push = valid_i & ready_o).
interface decryption_scheduler_if;
  import decryption_scheduler_pkg::*;

  logic [MST_DWIDTH-1:0] data_i;
  logic [1:0]            select_i;
  logic                  valid_i;
  logic                  ready_o;

  modport master (output data_i, output select_i, output valid_i, input ready_o);
  modport slave  (input data_i, input select_i, input valid_i, output ready_o);
endinterface

// File: rtl/decryption_scheduler_sync_fifo.sv
// rtl/decryption_scheduler_sync_fifo.sv - single-clock in-order FIFO with registered occupancy
// Purpose: generic synchronous FIFO, DEPTH a power of two >= 2.
// Ports: clk, rst (sync, active-high), push/wdata, pop/head, full, empty.
module decryption_scheduler_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // Occupancy MSB is set only when count == DEPTH (power-of-two depth).
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/decryption_scheduler.sv
// rtl/decryption_scheduler.sv - in-order word scheduler serialising bytes to three decryptor engines
// Purpose: buffers tagged words, drops invalid selects, issues 4 LSB-first bytes to a non-busy engine.
// Ports: clk_sys, rst_n (sync, active-high), in_if (word stream slave), busy_i[2:0],
//        data0..2_o/valid0..2_o (engine byte ports), err_o, drop_cnt_o, busy_o.
module decryption_scheduler
  import decryption_scheduler_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  rst_n,
  decryption_scheduler_if.slave in_if,
  input  logic [2:0]            busy_i,
  output logic [SYS_DWIDTH-1:0] data0_o,
  output logic                  valid0_o,
  output logic [SYS_DWIDTH-1:0] data1_o,
  output logic                  valid1_o,
  output logic [SYS_DWIDTH-1:0] data2_o,
  output logic                  valid2_o,
  output logic                  err_o,
  output logic [7:0]            drop_cnt_o,
  output logic                  busy_o
);
  state_e                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [MST_DWIDTH-1:0] word_q, word_d;
  logic [1:0]            sel_q, sel_d;
  logic [2:0]            valid_q, valid_d;
  logic [SYS_DWIDTH-1:0] data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;
  logic                  err_q, err_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic                  fifo_full, fifo_empty, push, pop;
  logic [MST_DWIDTH+1:0] head;
  logic [1:0]            head_sel;
  logic [MST_DWIDTH-1:0] head_word;
  logic [SYS_DWIDTH-1:0] beat_byte;

  assign in_if.ready_o = ~fifo_full;
  assign push          = in_if.valid_i & ~fifo_full;
  assign head_sel      = head[MST_DWIDTH+1:MST_DWIDTH];
  assign head_word     = head[MST_DWIDTH-1:0];
  assign beat_byte     = word_q[beat_q*SYS_DWIDTH +: SYS_DWIDTH];

  decryption_scheduler_sync_fifo #(
    .WIDTH (MST_DWIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (rst_n),
    .push  (push),
    .wdata ({in_if.select_i, in_if.data_i}),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    word_d     = word_q;
    sel_d      = sel_q;
    valid_d    = '0;
    data0_d    = '0;
    data1_d    = '0;
    data2_d    = '0;
    err_d      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_sel == SEL_INVALID) begin
            pop   = 1'b1;
            err_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          end else if (!engine_busy(head_sel, busy_i)) begin
            // Head-of-line blocking is intentional: a busy head stalls everything behind it.
            pop     = 1'b1;
            word_d  = head_word;
            sel_d   = head_sel;
            beat_d  = 2'd0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // busy_i is not consulted here: a started word always delivers all bytes.
        case (sel_q)
          SEL_CAESAR:  begin valid_d[0] = 1'b1; data0_d = beat_byte; end
          SEL_SCYTALE: begin valid_d[1] = 1'b1; data1_d = beat_byte; end
          SEL_ZIGZAG:  begin valid_d[2] = 1'b1; data2_d = beat_byte; end
          default:     valid_d = '0;
        endcase
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BYTES_PER_WORD - 1)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!engine_busy(sel_q, busy_i)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      word_q     <= '0;
      sel_q      <= '0;
      valid_q    <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign data0_o    = data0_q;
  assign data1_o    = data1_q;
  assign data2_o    = data2_q;
  assign valid0_o   = valid_q[0];
  assign valid1_o   = valid_q[1];
  assign valid2_o   = valid_q[2];
  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;
  assign busy_o     = (state_q != ST_IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_decryption_scheduler.sv
// tb/tb_decryption_scheduler.sv - self-checking bench for decryption_scheduler
module tb_decryption_scheduler;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic [2:0] busy_i;
  logic [7:0] data0_o, data1_o, data2_o, drop_cnt_o;
  logic       valid0_o, valid1_o, valid2_o, err_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  decryption_scheduler_if u_if ();

  decryption_scheduler dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .in_if      (u_if),
    .busy_i     (busy_i),
    .data0_o    (data0_o),
    .valid0_o   (valid0_o),
    .data1_o    (data1_o),
    .valid1_o   (valid1_o),
    .data2_o    (data2_o),
    .valid2_o   (valid2_o),
    .err_o      (err_o),
    .drop_cnt_o (drop_cnt_o),
    .busy_o     (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [2:0]  busy;
    logic [2:0]  e_valid;
    logic [23:0] e_bytes;
    logic        e_ready;
    logic        e_err;
    logic [7:0]  e_drop;
    logic        e_busy;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b1;
    u_if.valid_i  = 1'b0;
    busy_i        = 3'b000;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  logic [2:0]  vbus;
  logic [7:0]  got [$];
  logic        found, stray;
  int          pushed;
  logic [31:0] wa, wb, wc;

  initial begin
    rst_n         = 1'b1;
    u_if.valid_i  = 1'b0;
    u_if.select_i = 2'd0;
    u_if.data_i   = '0;
    busy_i        = 3'b000;

    // rst vld sel data busy | e_valid e_bytes{d2,d1,d0} ready err drop busy_o
    tbl[0]  = '{1'b1, 1'b1, 2'd1, 32'hDDCCBBAA, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'd1, 32'hDDCCBBAA, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'd1, 32'hDDCCBBAA, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 32'hDDCCBBAA, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b010, 24'h00AA00, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b010, 24'h00BB00, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b010, 24'h00CC00, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b010, 24'h00DD00, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 32'hDEADBEEF, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 32'h04030201, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b1, 8'd1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b100, 24'h010000, 1'b1, 1'b0, 8'd1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b100, 24'h020000, 1'b1, 1'b0, 8'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b100, 24'h030000, 1'b1, 1'b0, 8'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b100, 24'h040000, 1'b1, 1'b0, 8'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'd1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst_n         = tbl[i].rst;
      u_if.valid_i  = tbl[i].vld;
      u_if.select_i = tbl[i].sel;
      u_if.data_i   = tbl[i].data;
      busy_i        = tbl[i].busy;
      tick();
      check($sformatf("t%0d_valid", i), {29'd0, valid2_o, valid1_o, valid0_o}, {29'd0, tbl[i].e_valid});
      check($sformatf("t%0d_bytes", i), {8'd0, data2_o, data1_o, data0_o}, {8'd0, tbl[i].e_bytes});
      check($sformatf("t%0d_ready", i), {31'd0, u_if.ready_o}, {31'd0, tbl[i].e_ready});
      check($sformatf("t%0d_err", i), {31'd0, err_o}, {31'd0, tbl[i].e_err});
      check($sformatf("t%0d_drop", i), {24'd0, drop_cnt_o}, {24'd0, tbl[i].e_drop});
      check($sformatf("t%0d_busy", i), {31'd0, busy_o}, {31'd0, tbl[i].e_busy});
    end

    // Backpressure: four pushes fill the FIFO, fifth held off until engine 0 frees.
    busy_i        = 3'b111;
    u_if.select_i = 2'd0;
    for (int k = 0; k < 4; k++) begin
      u_if.data_i  = 32'h03020100 + 32'h04040404 * k;
      u_if.valid_i = 1'b1;
      tick();
      check($sformatf("bp_ready%0d", k), {31'd0, u_if.ready_o}, (k < 3) ? 32'd1 : 32'd0);
    end
    u_if.data_i = 32'h13121110;
    tick();
    check("bp_hold_ready", {31'd0, u_if.ready_o}, 32'd0);
    tick();
    check("bp_hold_valid", {29'd0, valid2_o, valid1_o, valid0_o}, 32'd0);
    busy_i = 3'b110;
    got.delete();
    stray = 1'b0;
    for (int c = 0; c < 80 && got.size() < 20; c++) begin
      found = u_if.valid_i & u_if.ready_o;
      tick();
      if (found) u_if.valid_i = 1'b0;
      if (valid0_o) got.push_back(data0_o);
      if (valid1_o | valid2_o) stray = 1'b1;
    end
    u_if.valid_i = 1'b0;
    check("bp_nbytes", got.size(), 32'd20);
    check("bp_stray", {31'd0, stray}, 32'd0);
    for (int b = 0; b < got.size(); b++) check($sformatf("bp_byte%0d", b), {24'd0, got[b]}, b);

    // Busy gating in WAIT and head-of-line blocking.
    do_reset();
    wa = 32'hA3A2A1A0; wb = 32'hB3B2B1B0; wc = 32'hC3C2C1C0;
    u_if.valid_i = 1'b1; u_if.select_i = 2'd2; u_if.data_i = wa; tick();
    u_if.data_i = wb; tick();
    busy_i = 3'b100;
    u_if.select_i = 2'd0; u_if.data_i = wc; tick();
    u_if.valid_i = 1'b0;
    found = valid2_o && data2_o == 8'hA3;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      found = valid2_o && data2_o == 8'hA3;
    end
    check("bg_a_done", {31'd0, found}, 32'd1);
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid0_o | valid2_o) stray = 1'b1;
    end
    check("bg_blocked", {31'd0, stray}, 32'd0);
    busy_i = 3'b000;
    tick();
    check("bg_f0", {29'd0, valid2_o, valid1_o, valid0_o}, 32'd0);
    tick();
    check("bg_f1", {29'd0, valid2_o, valid1_o, valid0_o}, 32'd0);
    tick();
    check("bg_f2_valid", {29'd0, valid2_o, valid1_o, valid0_o}, 32'd4);
    check("bg_f2_byte", {24'd0, data2_o}, 32'hB0);
    stray = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid0_o) stray = 1'b1;
    end
    check("bg_c_early", {31'd0, stray}, 32'd0);
    tick();
    check("bg_c_valid", {29'd0, valid2_o, valid1_o, valid0_o}, 32'd1);
    check("bg_c_byte", {24'd0, data0_o}, 32'hC0);

    // Drop counter saturation.
    do_reset();
    u_if.select_i = 2'd3; u_if.data_i = 32'h55AA55AA; u_if.valid_i = 1'b1;
    pushed = 0;
    for (int c = 0; c < 400 && pushed < 300; c++) begin
      if (u_if.ready_o) pushed++;
      tick();
    end
    u_if.valid_i = 1'b0;
    check("sat_pushed", pushed, 32'd300);
    for (int c = 0; c < 8; c++) tick();
    check("sat_drop", {24'd0, drop_cnt_o}, 32'd255);
    check("sat_busy", {31'd0, busy_o}, 32'd0);

    // Reset during ISSUE truncates the byte stream and flushes the FIFO.
    do_reset();
    u_if.valid_i = 1'b1; u_if.select_i = 2'd0;
    u_if.data_i = 32'hE3E2E1E0; tick();
    u_if.data_i = 32'hF3F2F1F0; tick();
    u_if.valid_i = 1'b0;
    found = valid0_o && data0_o == 8'hE1;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      found = valid0_o && data0_o == 8'hE1;
    end
    check("rm_beat1", {31'd0, found}, 32'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    vbus = {valid2_o, valid1_o, valid0_o};
    check("rm_valid", {29'd0, vbus}, 32'd0);
    check("rm_data0", {24'd0, data0_o}, 32'd0);
    check("rm_busy", {31'd0, busy_o}, 32'd0);
    check("rm_ready", {31'd0, u_if.ready_o}, 32'd1);
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid0_o | valid1_o | valid2_o | busy_o) stray = 1'b1;
    end
    check("rm_quiet", {31'd0, stray}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
